// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake and status.
// master = fetch unit side; slave = memory/decode/next-PC environment side.
interface ifetch_unit_if;
  logic [31:0] npc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        fetch_err;
  logic [31:0] inst_cnt;

  modport master (
    input  npc_in, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, pc_out, inst_out,
           imm16, imm26, fetch_err, inst_cnt
  );

  modport slave (
    output npc_in, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, pc_out, inst_out,
           imm16, imm26, fetch_err, inst_cnt
  );
endinterface

// File: rtl/ifetch_unit.sv
// PC register and instruction-fetch controller: one imem request per instruction,
// holds the returned word for decode and takes the next PC on the accept cycle.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;
  logic [31:0] cnt_q,   cnt_d;
  logic        err_q,   err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Response data is only captured in S_WAIT and the PC only moves on an accept,
  // so both stay frozen for the whole of S_HOLD regardless of backpressure.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          inst_d  = bus.imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (bus.npc_in[1:0] == 2'b00) begin
            pc_d    = bus.npc_in;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.imem_req   = (state_q == S_REQ);
    bus.inst_valid = (state_q == S_HOLD);
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc_out    = pc_q;
  assign bus.inst_out  = inst_q;
  assign bus.imm16     = inst_q[15:0];
  assign bus.imm26     = inst_q[25:0];
  assign bus.fetch_err = err_q;
  assign bus.inst_cnt  = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed table, hand-written corner sequences
// and a randomized run against a transaction-level model of PC/count/error state.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int last_req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model of the architectural state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;
  logic [31:0] m_inst;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          rdly;
    logic [31:0] npc;
    logic [15:0] exp_imm16;
    logic [25:0] exp_imm26;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input bit drive_rv);
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.imem_rvalid = drive_rv;
      bus.imem_rdata  = $urandom;
      tick();
      chk("rst_pc",    bus.pc_out,     32'h0000_3000);
      chk("rst_valid", bus.inst_valid, 32'd0);
      chk("rst_req",   bus.imem_req,   32'd0);
      chk("rst_cnt",   bus.inst_cnt,   32'd0);
      chk("rst_err",   bus.fetch_err,  32'd0);
      chk("rst_inst",  bus.inst_out,   32'd0);
    end
    rst = 1'b0;
    bus.imem_rvalid = 1'b0;
    m_pc = 32'h0000_3000; m_cnt = 0; m_err = 0; m_inst = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  // Fetch one word: wait for the request, answer after lat idle WAIT cycles.
  task automatic fetch(input logic [31:0] rdata, input int lat, input bit junk);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    last_req_cyc = cyc;
    chk("req_addr",     bus.imem_addr,  m_pc);
    chk("req_valid",    bus.inst_valid, 32'd0);
    if (junk) begin
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    tick();
    bus.imem_rvalid = 1'b0;
    chk("req_pulse", bus.imem_req, 32'd0);
    for (int i = 0; i < lat; i++) begin
      if (junk) bus.inst_ready = 1'($urandom_range(0, 1));
      chk("wait_valid", bus.inst_valid, 32'd0);
      tick();
      chk("wait_req", bus.imem_req, 32'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rdata;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    bus.inst_ready  = 1'b0;
    m_inst = rdata;
    chk("hold_valid", bus.inst_valid, 32'd1);
    chk("hold_inst",  bus.inst_out,   m_inst);
    chk("hold_imm16", {16'd0, bus.imm16}, {16'd0, m_inst[15:0]});
    chk("hold_imm26", {6'd0, bus.imm26},  {6'd0, m_inst[25:0]});
    chk("hold_pc",    bus.pc_out,     m_pc);
  endtask

  // Hold for rdly backpressure cycles, then accept with npc.
  task automatic accept(input logic [31:0] npc, input int rdly, input bit junk);
    for (int i = 0; i < rdly; i++) begin
      bus.inst_ready = 1'b0;
      bus.npc_in = junk ? $urandom : npc;
      if (junk) begin
        bus.imem_rvalid = 1'($urandom_range(0, 1));
        bus.imem_rdata  = $urandom;
      end
      tick();
      chk("bp_valid", bus.inst_valid, 32'd1);
      chk("bp_inst",  bus.inst_out,   m_inst);
      chk("bp_pc",    bus.pc_out,     m_pc);
      chk("bp_req",   bus.imem_req,   32'd0);
      chk("bp_cnt",   bus.inst_cnt,   m_cnt);
    end
    bus.imem_rvalid = 1'b0;
    bus.npc_in      = npc;
    bus.inst_ready  = 1'b1;
    tick();
    bus.inst_ready  = 1'b0;
    bus.npc_in      = $urandom;
    m_cnt = m_cnt + 1;
    if (npc[1:0] == 2'b00) m_pc = npc;
    else                   m_err = 1'b1;
    chk("acc_valid", bus.inst_valid, 32'd0);
    chk("acc_cnt",   bus.inst_cnt,   m_cnt);
    chk("acc_pc",    bus.pc_out,     m_pc);
    chk("acc_err",   bus.fetch_err,  {31'd0, m_err});
    if (!m_err) begin
      chk("acc_req",  bus.imem_req,  32'd1);
      chk("acc_addr", bus.imem_addr, npc);
    end
  endtask

  task automatic err_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.inst_ready  = 1'($urandom_range(0, 1));
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      bus.imem_rdata  = $urandom;
      bus.npc_in      = $urandom;
      tick();
      chk("err_req",   bus.imem_req,   32'd0);
      chk("err_valid", bus.inst_valid, 32'd0);
      chk("err_flag",  bus.fetch_err,  32'd1);
      chk("err_cnt",   bus.inst_cnt,   m_cnt);
    end
    bus.inst_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int t0;
    int t1;

    tbl[0] = '{32'h0800_0C10, 1, 0, 32'h0000_3040, 16'h0C10, 26'h000_0C10, 32'h0000_3040};
    tbl[1] = '{32'h2402_0005, 0, 0, 32'h0000_3044, 16'h0005, 26'h002_0005, 32'h0000_3044};
    tbl[2] = '{32'h8C43_0004, 2, 5, 32'hFFFF_FFFC, 16'h0004, 26'h043_0004, 32'hFFFF_FFFC};
    tbl[3] = '{32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 16'hFFFF, 26'h3FF_FFFF, 32'h0000_0000};
    tbl[4] = '{32'h0000_0000, 3, 2, 32'h1000_0008, 16'h0000, 26'h000_0000, 32'h1000_0008};
    tbl[5] = '{32'hAC22_8000, 0, 0, 32'h0000_3100, 16'h8000, 26'h022_8000, 32'h0000_3100};

    bus.npc_in = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.inst_ready = 0;

    // Reset and first request timing
    do_reset(2, 1'b0);
    chk("post_rst_req0", bus.imem_req, 32'd0);
    tick();
    chk("first_req",      bus.imem_req,  32'd1);
    chk("first_req_addr", bus.imem_addr, 32'h0000_3000);

    // Directed table
    foreach (tbl[i]) begin
      fetch(tbl[i].rdata, tbl[i].lat, 1'b0);
      chk("tbl_imm16", {16'd0, bus.imm16}, {16'd0, tbl[i].exp_imm16});
      chk("tbl_imm26", {6'd0, bus.imm26},  {6'd0, tbl[i].exp_imm26});
      accept(tbl[i].npc, tbl[i].rdly, 1'b0);
      chk("tbl_pc",  bus.pc_out,   tbl[i].exp_pc);
      chk("tbl_cnt", bus.inst_cnt, 32'(i + 1));
    end

    // Back-to-back throughput with zero-wait memory and ready high
    fetch(32'h1111_0000, 0, 1'b0);
    t0 = last_req_cyc;
    accept(32'h0000_3104, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      fetch(32'h1111_0001 + k, 0, 1'b0);
      t1 = last_req_cyc;
      chk("throughput", 32'(t1 - t0), 32'd3);
      t0 = t1;
      accept(32'h0000_3108 + 32'(4 * k), 0, 1'b0);
    end

    // Misaligned next PC traps into the sticky error state
    fetch(32'h0123_4567, 1, 1'b0);
    accept(32'h0000_3042, 0, 1'b0);
    err_idle(20);
    do_reset(1, 1'b0);
    fetch(32'h0000_0001, 0, 1'b0);
    chk("refetch_pc", bus.pc_out, 32'h0000_3000);

    // Reset in the middle of an outstanding fetch
    accept(32'h0000_3200, 0, 1'b0);
    wait_req(ok);
    tick();
    do_reset(2, 1'b1);
    chk("midwait_cnt",   bus.inst_cnt,   32'd0);
    chk("midwait_valid", bus.inst_valid, 32'd0);
    fetch(32'h0BAD_F00D, 0, 1'b0);
    accept(32'h0000_3300, 0, 1'b0);

    // Randomized transactions with junk on ignored inputs
    for (int n = 0; n < 150; n++) begin
      logic [31:0] npc;
      fetch($urandom, $urandom_range(0, 4), 1'b1);
      npc = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      accept(npc, $urandom_range(0, 3), 1'b1);
      if (m_err) begin
        err_idle(3);
        do_reset(1, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
